// File: rtl/regfile_bus_reader_if.sv
// Handshake and A-bus signals between the register-bank reader and its
// surroundings: request/abort inputs, bank enables and data, and the word stream.
interface regfile_bus_reader_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = 3
);
    logic             start;
    logic [AW-1:0]    addr_lo;
    logic [AW-1:0]    addr_hi;
    logic             abort;
    logic [NREGS-1:0] oea;
    logic [WIDTH-1:0] DA;
    logic [WIDTH-1:0] dout;
    logic [AW-1:0]    dout_addr;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  start, addr_lo, addr_hi, abort, DA, dout_ready,
        output oea, dout, dout_addr, dout_valid, busy, done, err
    );

    modport slave (
        output start, addr_lo, addr_hi, abort, DA, dout_ready,
        input  oea, dout, dout_addr, dout_valid, busy, done, err
    );
endinterface

// File: rtl/regfile_bus_reader.sv
// Walks an inclusive address range on the shared A bus, enabling one register at a
// time, and streams each captured word out over a valid/ready handshake.
module regfile_bus_reader #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input logic                  clk,
    input logic                  reset,
    regfile_bus_reader_if.master bus
);
    typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, PRESENT, DONE} state_t;

    state_t        state;
    logic [AW-1:0] cur;
    logic [AW-1:0] last;
    logic [AW-1:0] hi_clamped;
    logic          range_bad;

    function automatic logic [AW-1:0] clamp_addr(input logic [AW-1:0] a);
        if (int'(a) >= NREGS) return AW'(NREGS - 1);
        return a;
    endfunction

    function automatic logic [NREGS-1:0] enable_for(input logic [AW-1:0] a);
        return NREGS'(1) << a;
    endfunction

    always_comb begin
        hi_clamped = clamp_addr(bus.addr_hi);
        range_bad  = (int'(bus.addr_lo) >= NREGS) || (bus.addr_lo > hi_clamped);
    end

    // oea is only ever loaded with a single enable_for() value or zero, so the
    // bank never sees two drivers on the A bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cur            <= '0;
            last           <= '0;
            bus.oea        <= '0;
            bus.dout       <= '0;
            bus.dout_addr  <= '0;
            bus.dout_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else if (bus.abort && state != IDLE) begin
            state          <= IDLE;
            bus.oea        <= '0;
            bus.dout_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (range_bad) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                        end else begin
                            cur      <= bus.addr_lo;
                            last     <= hi_clamped;
                            bus.oea  <= enable_for(bus.addr_lo);
                            bus.busy <= 1'b1;
                            state    <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    bus.dout       <= bus.DA;
                    bus.dout_addr  <= cur;
                    bus.dout_valid <= 1'b1;
                    bus.oea        <= '0;
                    state          <= PRESENT;
                end
                PRESENT: begin
                    if (bus.dout_valid && bus.dout_ready) begin
                        bus.dout_valid <= 1'b0;
                        if (cur == last) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            cur     <= cur + 1'b1;
                            bus.oea <= enable_for(AW'(cur + 1'b1));
                            state   <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/regfile_bus_reader.md
Name: regfile_bus_reader

Overview:
- Sequenced reader for the 16-bit register bank on the shared tri-state A bus.
- Given an inclusive address range, it does the following for each register in turn:
  - drives exactly one output-enable line;
  - samples the A bus;
  - presents the word on a valid/ready output stream.
- Used for register dump/debug readout and for block transfers out of the register bank. It owns the A-bus enables only while busy.

Parameters:
- WIDTH, 16, data width of the A bus and of the output word.
- NREGS, 8, number of registers on the bus, one output-enable line per register.
- AW, 3, address width; must satisfy 2**AW >= NREGS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a readout; honoured only in IDLE.
- addr_lo  input  AW  first register address; sampled with start.
- addr_hi  input  AW  last register address, inclusive; sampled with start.
- abort  input  1  synchronous cancel of a readout in progress.
- oea  output  NREGS  one-hot A-bus output enables to the register bank; zero when not reading.
- DA  input  WIDTH  shared A bus driven by the register bank.
- dout  output  WIDTH  captured register word.
- dout_addr  output  AW  address of the word on dout.
- dout_valid  output  1  dout and dout_addr are valid.
- dout_ready  input  1  consumer accepts the word when dout_valid and dout_ready are both high.
- busy  output  1  high from the first cycle after an accepted start until the return to IDLE.
- done  output  1  one-cycle pulse when a readout completes.
- err  output  1  one-cycle pulse, coincident with done, when the range was rejected.

Behaviour:
- Reset values: oea=0, dout=0, dout_addr=0, dout_valid=0, busy=0, done=0, err=0, state=IDLE. Reset asserted mid-readout has the same effect on the next edge.
- All outputs are registered. oea is always all-zero or one-hot; two bits are never high at once. This prevents bus contention.

States:
- IDLE:
  - start=1 and addr_lo<=addr_hi: latch cur=addr_lo, last=addr_hi, go to DRIVE, busy=1.
  - start=1 and addr_lo>addr_hi: go to DONE with err flagged.
  - start=1 and addr_lo>=NREGS: treated as a range error, same as above.
  - addr_hi>=NREGS: clamped to NREGS-1.
- DRIVE:
  - oea[cur]=1. This is the bus settle cycle; no sampling.
  - Next state is SAMPLE.
- SAMPLE:
  - oea[cur] stays 1.
  - At the end of the cycle: dout<=DA, dout_addr<=cur, dout_valid<=1, oea<=0.
  - Next state is PRESENT.
- PRESENT:
  - oea=0. dout, dout_addr and dout_valid are held stable until the handshake.
  - On dout_valid&&dout_ready, dout_valid<=0, then:
    - cur==last: go to DONE;
    - otherwise: cur<=cur+1, go to DRIVE.
- DONE:
  - done=1 for one cycle; err=1 too if the range was rejected. busy=0.
  - Next state is IDLE.

Timing and rules:
- Latency: start sampled at edge k gives DRIVE in cycle k+1, SAMPLE in k+2, and dout_valid high from k+3.
- With dout_ready held high, throughput is one word per 3 cycles. An N-word readout completes with done at cycle k+3N+1.
- start while busy is ignored; it is not queued.
- abort has priority over everything except reset. From any non-IDLE state, the next edge gives state=IDLE, oea=0, dout_valid=0, busy=0. No done or err pulse is produced. dout and dout_addr keep their last values.
- abort and dout handshake in the same cycle: abort wins and the word counts as not delivered.
- Single-register range (addr_lo==addr_hi): exactly one word, then done.
- cur increments only after a handshake. There is no wrap-around, because last<=NREGS-1.

Test Plan:
- Reset then idle 5 cycles → oea=0, dout_valid=0, busy=0, done=0 throughout.
- Bank model holds R[i]=16'hA000+i. Apply start, addr_lo=2, addr_hi=5, dout_ready=1 → words A002..A005 with dout_addr 2..5, each dout_valid 3 cycles apart. oea sequence is 04,04,0,08,08,0,… and is never multi-hot. done pulses once at cycle k+13, err=0.
- Same range with dout_ready low for 4 cycles on the 2nd word → dout=A003 and dout_addr=3 held stable, oea=0 while waiting. After ready rises, the readout resumes with no loss or duplication.
- Apply start with addr_lo=6, addr_hi=1 → no oea activity; done=1 and err=1 for the same single cycle; busy stays 0.
- Range 0..7, abort asserted in the SAMPLE cycle of address 3 → next cycle oea=0, dout_valid=0, busy=0, no done. A following start with addr_lo=addr_hi=7 returns exactly one word, A007, then done.
- Apply start during a readout of range 0..3, and reset in the PRESENT state of address 1 → the mid-run start has no effect. Reset returns all outputs to 0 on the next edge.
